// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide on operand magnitudes, with
//               sign correction applied when the result is formed. Divide by
//               zero and signed overflow complete immediately.
//               Optional macro MULDIV_EARLY_OUT_EN: multiplies finish as soon
//               as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_q;      // product / quotient must be negated
    logic              r_neg_r;      // remainder must be negated (dividend sign)
    // Multiply: r_acc = partial product, r_opa = shifted multiplicand,
    //           r_opb = remaining multiplier.
    // Divide:   r_acc[XLEN-1:0] = partial remainder, r_opa[XLEN-1:0] = divisor,
    //           r_opb = dividend bits shifting out / quotient bits shifting in.
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_opa;
    logic [XLEN-1:0]   r_opb;

    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_mul_zero;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    logic [2*XLEN-1:0] w_prod_next;
    logic [XLEN-1:0]   w_mpl_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN-1:0]   w_diff;
    logic              w_q_bit;
    logic [XLEN-1:0]   w_rem_next;
    logic [XLEN-1:0]   w_quo_next;
    logic [2*XLEN-1:0] w_prod_fin;
    logic [XLEN-1:0]   w_quo_fin;
    logic [XLEN-1:0]   w_rem_fin;
    logic [XLEN-1:0]   w_final;
    logic              w_early;
    logic              w_last;

    assign busy = (r_state == S_BUSY);
    assign done = (r_state == S_DONE);

    // Operand decode at request time: signedness, magnitudes and special cases
    always_comb begin
        w_sign_a   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
        w_sign_b   = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                     (funct3 == 3'b110);
        w_neg_a    = w_sign_a && operand_a[XLEN-1];
        w_neg_b    = w_sign_b && operand_b[XLEN-1];
        w_abs_a    = w_neg_a ? -operand_a : operand_a;
        w_abs_b    = w_neg_b ? -operand_b : operand_b;
        w_div_zero = funct3[2] && (operand_b == '0);
        w_div_ovf  = funct3[2] && !funct3[0] &&
                     (operand_a == c_int_min) && (operand_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        w_mul_zero = !funct3[2] && (operand_b == '0);
`else
        w_mul_zero = 1'b0;
`endif
        w_special  = w_div_zero || w_div_ovf || w_mul_zero;
        if (w_div_zero) begin
            w_special_res = funct3[1] ? operand_a : '1;
        end else if (w_div_ovf) begin
            w_special_res = funct3[1] ? '0 : c_int_min;
        end else begin
            w_special_res = '0;
        end
    end

    // One shift-add / restoring-divide step and the sign-corrected final result
    always_comb begin
        w_prod_next = r_acc + (r_opb[0] ? r_opa : '0);
        w_mpl_next  = r_opb >> 1;
        w_rem_sh    = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
        w_q_bit     = (w_rem_sh >= {1'b0, r_opa[XLEN-1:0]});
        // Only used when the subtraction succeeds, so the truncated width is exact
        w_diff      = w_rem_sh[XLEN-1:0] - r_opa[XLEN-1:0];
        w_rem_next  = w_q_bit ? w_diff : w_rem_sh[XLEN-1:0];
        w_quo_next  = {r_opb[XLEN-2:0], w_q_bit};
        w_prod_fin  = r_neg_q ? -w_prod_next : w_prod_next;
        w_quo_fin   = r_neg_q ? -w_quo_next : w_quo_next;
        w_rem_fin   = r_neg_r ? -w_rem_next : w_rem_next;
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem_fin : w_quo_fin;
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod_fin[XLEN-1:0];
        end else begin
            w_final = w_prod_fin[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_EARLY_OUT_EN
        w_early = !r_op[2] && (w_mpl_next == '0);
`else
        w_early = 1'b0;
`endif
        w_last = (r_cnt == c_last_iter) || w_early;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= funct3;
                        rd_out  <= rd_in;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        if (funct3[2]) begin
                            r_opa <= {{XLEN{1'b0}}, w_abs_b};
                            r_opb <= w_abs_a;
                        end else begin
                            r_opa <= {{XLEN{1'b0}}, w_abs_a};
                            r_opb <= w_abs_b;
                        end
                        if (w_special) begin
                            result  <= w_special_res;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[2]) begin
                        r_acc <= {{XLEN{1'b0}}, w_rem_next};
                        r_opb <= w_quo_next;
                    end else begin
                        r_acc <= w_prod_next;
                        r_opa <= r_opa << 1;
                        r_opb <= w_mpl_next;
                    end
                    if (w_last) begin
                        result  <= w_final;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit. Stimulus pushes expected
//               result/tag/latency; a negedge monitor pops on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Cycles from accept to done for a multiply whose |multiplier| has `bits` significant bits
    function automatic int mul_lat(input int bits);
`ifdef MULDIV_EARLY_OUT_EN
        return bits + 1;
`else
        return (bits == 0) ? 33 : 33;
`endif
    endfunction

    // Monitor: tracks acceptance, busy cycles and checks every done pulse
    int cyc = 0;
    int t0 = 0;
    int busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (busy) busy_cnt++;
        if (done) begin
            chk("done_not_consecutive", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=0x%08h expected=none", result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                chk("latency", 32'(cyc - t0), 32'(e.lat));
                chk("busy_cycles", 32'(busy_cnt), 32'(e.lat - 1));
            end
        end
        if (start && !busy && !done && !reset) begin
            t0       = cyc;
            busy_cnt = 0;
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy || done) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL wait_idle_timeout actual=busy%0b_done%0b required=idle", busy, done);
                break;
            end
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] r, input int lat);
        exp_t e;
        wait_idle();
        funct3    = f;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        start     = 1'b1;
        e.res = r; e.rd = rd; e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        start     = 1'b0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1234_5678;
        rd_in     = 5'd31;
    endtask

    initial begin
        int n;
        exp_t e;
        reset = 1'b1; start = 1'b0; funct3 = '0;
        operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);

        // Basic MUL
        issue(3'b000, 32'd7, 32'd3, 5'd5, 32'h15, mul_lat(2));
        // Signed/unsigned high-half variants on -1 x -1
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, mul_lat(32));
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001, mul_lat(32));
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, mul_lat(32));
        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, mul_lat(32));
        // Division and remainder
        issue(3'b100, 32'hFFFFFFEC, 32'd6, 5'd6, 32'hFFFFFFFD, 33);
        issue(3'b110, 32'hFFFFFFEC, 32'd6, 5'd7, 32'hFFFFFFFE, 33);
        issue(3'b101, 32'd100, 32'd7, 5'd8, 32'd14, 33);
        issue(3'b111, 32'd100, 32'd7, 5'd9, 32'd2, 33);
        // Immediate special cases
        issue(3'b101, 32'd45, 32'd0, 5'd10, 32'hFFFFFFFF, 1);
        issue(3'b110, 32'd45, 32'd0, 5'd11, 32'd45, 1);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1);

        // Start pulsed mid-operation must be ignored
        issue(3'b100, 32'd1000, 32'd10, 5'd14, 32'd100, 33);
        repeat (5) @(posedge clk);
        #1;
        funct3 = 3'b101; operand_a = 32'd5; operand_b = 32'd5; rd_in = 5'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // Reset in the middle of an operation
        wait_idle();
        funct3 = 3'b101; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd12;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd_out", {27'd0, rd_out}, 32'd0);
        issue(3'b011, 32'h00010000, 32'h00010000, 5'd15, 32'h00000001, mul_lat(17));

        // Back-to-back with start held high
        wait_idle();
        funct3 = 3'b000; operand_a = 32'd6; operand_b = 32'd8; rd_in = 5'd3;
        start = 1'b1;
        e.res = 32'd48; e.rd = 5'd3; e.lat = mul_lat(4);
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!done && n < 200);
        operand_a = 32'd5; operand_b = 32'd2; rd_in = 5'd4;
        e.res = 32'd10; e.rd = 5'd4; e.lat = mul_lat(2);
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!busy && !done && n < 200);
        start = 1'b0;

        // Drain the scoreboard
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file.
- Consumes read_data1/read_data2 as operand_a/operand_b, plus the destination register index.
- Returns a registered result with a write-back tag for the register file write port.
- Multi-cycle: asserts busy so the control path stalls the PC and suppresses RegWrite until done.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  32  rs1 value (multiplicand/dividend)
operand_b  input  32  rs2 value (multiplier/divisor)
rd_in  input  5  destination register index
busy  output  1  operation in progress
done  output  1  one-cycle pulse; result/rd_out valid
result  output  32  write-back data
rd_out  output  5  destination tag, captured at start

Behaviour:
- Reset: synchronous active-high on clk, highest priority, aborts any operation.
  - Next state IDLE; busy=0, done=0, result=0, rd_out=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at edge E0 captures funct3, rd_in, abs(operands) and sign flags.
  - Signed inputs: MULH both operands; MULHSU operand_a only; DIV/REM both.
  - Clears the 64-bit accumulator and sets counter=0; next state BUSY.
  - start=0 holds IDLE.
- Special cases, decided at E0:
  - Go straight to DONE; done pulses in the cycle after E0; no BUSY cycles.
  - Divide by zero (operand_b=0): DIV/DIVU result=0xFFFFFFFF; REM/REMU result=operand_a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- BUSY: one iteration per edge; counter increments each edge.
  - Multiply: radix-2 shift-add, 64-bit unsigned product of magnitudes.
  - Divide: restoring, one quotient bit per edge, 32-bit remainder.
  - After 32 iterations (edge E32): result formed, next state DONE.
- Result formation:
  - MUL: low 32 bits of the signed-corrected product.
  - MULH/MULHSU/MULHU: high 32 bits of the signed-corrected product.
  - Product is negated (two's complement, 64-bit) when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
  - result and rd_out are held stable until the next accepted start.
- busy: 1 in BUSY only; 0 in IDLE and DONE. start in BUSY/DONE is ignored, never queued.
- Nominal latency:
  - start at E0 -> done high in the cycle after E32 (33 cycles).
  - Back-to-back: next start accepted at the edge after DONE.
- Operands need not be held after E0; rd_out reflects rd_in captured at E0.

Optional Feature:
MULDIV_EARLY_OUT_EN:
- Defined:
  - In multiply ops, when the remaining (shifted) multiplier register becomes 0 after an iteration, the unit transitions to DONE at that edge.
  - A zero multiplier at E0 goes directly to DONE, like a special case.
  - Division latency is unchanged.
- Undefined: all non-special operations take exactly 32 BUSY iterations.

Test Plan:
1. MUL a=7, b=3, rd_in=5 -> done in cycle after E32; result=21 (0x15); rd_out=5; busy high 32 cycles.
   - With MULDIV_EARLY_OUT_EN: done after E2.
2. MULH a=0xFFFFFFFF(-1), b=0xFFFFFFFF(-1) -> result=0x00000000; MUL on the same operands -> 0x00000001; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
3. DIV a=-20 (0xFFFFFFEC), b=6 -> result=0xFFFFFFFD(-3); REM on the same operands -> 0xFFFFFFFE(-2); DIVU 100/7 -> 14; REMU -> 2.
4. DIVU a=45, b=0 -> done in cycle after E0, result=0xFFFFFFFF; REM a=45, b=0 -> 45; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
5. Start a DIV, pulse start again mid-BUSY with different operands -> second request ignored, first result correct.
   - Then assert reset at iteration 10 of a new op -> next cycle busy=0, done=0, result=0, rd_out=0; a following MULHU 0x10000 x 0x10000 -> 0x00000001.
6. Back-to-back MUL 6x8 then MUL 5x2 with start held high -> done pulses for 48 then 10; second start accepted at the edge after DONE; done never high two consecutive cycles.
